// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent WIDTH-bit up/down counters, each with
// an overflow supervisor (RES/CNT/OVF/ERR), parallel load and a wrap pulse.
module counter_bank #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       ena,
   input  logic [CHANNELS-1:0]       dir,
   input  logic [CHANNELS-1:0]       reinit,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] load_value,
   input  logic [CHANNELS-1:0]       clr_overflow,
   output logic [CHANNELS*WIDTH-1:0] value,
   output logic [CHANNELS-1:0]       overflow,
   output logic [CHANNELS-1:0]       overflow_err,
   output logic [CHANNELS-1:0]       wrap_pulse,
   output logic                      any_err
);
   typedef enum logic [1:0] {RES = 2'b00, CNT = 2'b01, OVF = 2'b11, ERR = 2'b10} state_t;
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      state_t           state, state_next;
      logic [WIDTH-1:0] cnt, cnt_next;
      logic             pulse, do_load, counting, term, wrap;
      always_ff @(posedge clk) begin
         if (reset || reinit[c]) begin
            state <= RES;
            cnt   <= '0;
            pulse <= 1'b0;
         end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pulse <= wrap;
         end
      end
      // a load that is honoured suppresses counting (and so wrapping) that cycle
      always_comb begin
         do_load  = load[c] && state != RES;
         counting = ena[c] && (state == CNT || state == OVF) && !do_load;
         term     = dir[c] ? &cnt : ~|cnt;
         wrap     = counting && term;
         cnt_next = do_load ? load_value[c*WIDTH +: WIDTH] :
                    counting ? (dir[c] ? cnt + 1'b1 : cnt - 1'b1) : cnt;
         case (state)
            RES:     state_next = CNT;
            CNT:     state_next = wrap ? OVF : CNT;
            OVF:     state_next = wrap ? (clr_overflow[c] ? OVF : ERR) : (clr_overflow[c] ? CNT : OVF);
            default: state_next = ERR;
         endcase
      end
      assign value[c*WIDTH +: WIDTH] = cnt;
      assign overflow[c]     = state == OVF;
      assign overflow_err[c] = state == ERR;
      assign wrap_pulse[c]   = pulse;
   end
   assign any_err = |overflow_err;
endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed vectors with hand-computed expectations for counter_bank.
module tb_counter_bank;
   localparam int W = 8;
   localparam int N = 4;
   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   ena, dir, reinit, load, clr_overflow;
   logic [N*W-1:0] load_value;
   logic [N*W-1:0] value;
   logic [N-1:0]   overflow, overflow_err, wrap_pulse;
   logic           any_err;
   int             errors = 0;
   int             checks = 0;

   counter_bank #(.WIDTH(W), .CHANNELS(N)) dut (
      .clk(clk), .reset(reset), .ena(ena), .dir(dir), .reinit(reinit),
      .load(load), .load_value(load_value), .clr_overflow(clr_overflow),
      .value(value), .overflow(overflow), .overflow_err(overflow_err),
      .wrap_pulse(wrap_pulse), .any_err(any_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] ch(input int i);
      return value[i*W +: W];
   endfunction

   initial begin
      reset = 1'b1; ena = '0; dir = '0; reinit = '0; load = '0;
      clr_overflow = '0; load_value = '0;
      tick(2);
      chk("rst value", value, 0);
      chk("rst overflow", overflow, 0);
      chk("rst err", overflow_err, 0);
      chk("rst wrap", wrap_pulse, 0);
      chk("rst any_err", any_err, 0);

      // ena ignored while leaving RES
      ena[0] = 1'b1; dir[0] = 1'b1; reset = 1'b0;
      tick();
      chk("res edge ch0", ch(0), 0);
      tick();
      chk("first count ch0", ch(0), 1);
      tick(254);
      chk("ch0 at ff", ch(0), 8'hff);
      chk("ch0 no ovf yet", overflow[0], 0);
      tick();
      chk("ch0 wrapped", ch(0), 0);
      chk("ch0 ovf", overflow[0], 1);
      chk("ch0 wrap pulse", wrap_pulse[0], 1);
      chk("others idle", value[N*W-1:W], 0);
      ena[0] = 1'b0;
      tick();
      chk("ch0 pulse one cycle", wrap_pulse[0], 0);
      chk("ch0 ovf held", overflow[0], 1);
      clr_overflow[0] = 1'b1;
      tick();
      chk("ch0 ovf cleared", overflow[0], 0);
      clr_overflow[0] = 1'b0;

      // channel 1 down count into OVF then ERR
      load[1] = 1'b1; load_value[W +: W] = 8'h02; dir[1] = 1'b0; ena[1] = 1'b1;
      tick();
      chk("ch1 loaded", ch(1), 2);
      load[1] = 1'b0;
      tick();
      chk("ch1 1", ch(1), 1);
      tick();
      chk("ch1 0", ch(1), 0);
      tick();
      chk("ch1 ff", ch(1), 8'hff);
      chk("ch1 ovf", overflow[1], 1);
      chk("ch1 pulse", wrap_pulse[1], 1);
      tick(255);
      chk("ch1 0 again", ch(1), 0);
      tick();
      chk("ch1 err", overflow_err[1], 1);
      chk("ch1 err ovf off", overflow[1], 0);
      chk("any_err", any_err, 1);
      chk("ch1 err value", ch(1), 8'hff);
      clr_overflow[1] = 1'b1;
      tick(2);
      chk("ch1 frozen", ch(1), 8'hff);
      chk("ch1 err sticky", overflow_err[1], 1);
      clr_overflow[1] = 1'b0; ena[1] = 1'b0;

      // channel 2: wrap and clear on the same edge re-arms OVF
      load[2] = 1'b1; load_value[2*W +: W] = 8'h00; dir[2] = 1'b0; ena[2] = 1'b1;
      tick();
      chk("ch2 load no count", ch(2), 0);
      load[2] = 1'b0;
      tick();
      chk("ch2 ovf ff", ch(2), 8'hff);
      chk("ch2 ovf", overflow[2], 1);
      dir[2] = 1'b1; clr_overflow[2] = 1'b1;
      tick();
      chk("ch2 rearm value", ch(2), 0);
      chk("ch2 rearm ovf", overflow[2], 1);
      chk("ch2 rearm pulse", wrap_pulse[2], 1);
      chk("ch2 rearm no err", overflow_err[2], 0);
      clr_overflow[2] = 1'b0; ena[2] = 1'b0;

      // channel 3 into ERR, then reinit
      load[3] = 1'b1; load_value[3*W +: W] = 8'h00; dir[3] = 1'b0; ena[3] = 1'b1;
      tick();
      load[3] = 1'b0;
      tick();
      chk("ch3 ovf", overflow[3], 1);
      load[3] = 1'b1;
      tick();
      chk("ch3 load in ovf", ch(3), 0);
      chk("ch3 load no pulse", wrap_pulse[3], 0);
      load[3] = 1'b0;
      tick();
      chk("ch3 err", overflow_err[3], 1);
      reinit[3] = 1'b1;
      tick();
      chk("ch3 reinit value", ch(3), 0);
      chk("ch3 reinit err", overflow_err[3], 0);
      chk("ch3 reinit pulse", wrap_pulse[3], 0);
      reinit[3] = 1'b0; dir[3] = 1'b1;
      tick();
      chk("ch3 res edge", ch(3), 0);
      tick();
      chk("ch3 resumed", ch(3), 1);
      chk("ch0 unaffected", ch(0), 0);
      chk("ch1 unaffected", ch(1), 8'hff);
      chk("ch2 unaffected", ch(2), 0);
      chk("err vector", overflow_err, 4'b0010);
      chk("ovf vector", overflow, 4'b0100);

      // load beats ena on channel 0
      load[0] = 1'b1; load_value[0 +: W] = 8'hff; ena[0] = 1'b1; dir[0] = 1'b1;
      tick();
      chk("ch0 load ff", ch(0), 8'hff);
      chk("ch0 load no ovf", overflow[0], 0);
      chk("ch0 load no pulse", wrap_pulse[0], 0);
      load[0] = 1'b0;
      tick();
      chk("ch0 wrap after load", ch(0), 0);
      chk("ch0 ovf after load", overflow[0], 1);
      chk("ch0 pulse after load", wrap_pulse[0], 1);

      // global reset mid-count
      ena = '1;
      tick(3);
      reset = 1'b1;
      tick();
      chk("grst value", value, 0);
      chk("grst ovf", overflow, 0);
      chk("grst err", overflow_err, 0);
      chk("grst pulse", wrap_pulse, 0);
      chk("grst any_err", any_err, 0);

      // load is ignored in RES
      ena = '0; load[0] = 1'b1; load_value[0 +: W] = 8'h55; reset = 1'b0;
      tick();
      chk("load ignored in RES", ch(0), 0);
      tick();
      chk("load in CNT", ch(0), 8'h55);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/counter_bank.md
# counter_bank

Multi-channel event counter bank: CHANNELS independent WIDTH-bit up/down counters, each with a per-channel overflow supervisor state machine (RES/CNT/OVF/ERR), parallel load, and a per-channel wrap pulse. It is the parametrised successor of the team's single-channel overflow counter. It sits beside the performance/event logic, where software polls values and clears overflows per channel.

## Interface
- WIDTH, 8: counter width per channel, ≥2
- CHANNELS, 4: number of independent channels, ≥1
- clk  in  1  clock, all logic rising-edge
- reset  in  1  reset, synchronous, active-high; clock clk
- ena  in  CHANNELS  per-channel count enable
- dir  in  CHANNELS  per-channel direction: 1 = up, 0 = down
- reinit  in  CHANNELS  per-channel synchronous re-initialise
- load  in  CHANNELS  per-channel parallel load strobe
- load_value  in  CHANNELS*WIDTH  load data; channel i at [i*WIDTH +: WIDTH]
- clr_overflow  in  CHANNELS  per-channel overflow acknowledge
- value  out  CHANNELS*WIDTH  registered counter values, same packing
- overflow  out  CHANNELS  channel in OVF
- overflow_err  out  CHANNELS  channel in ERR
- wrap_pulse  out  CHANNELS  registered 1-cycle pulse after each wrap
- any_err  out  1  OR of overflow_err

## Operation
- Per-channel state encoding: RES=00, CNT=01, OVF=11, ERR=10. overflow = (state==OVF), overflow_err = (state==ERR), decoded from state flops only.
- Terminal condition term = dir ? (value == all-ones) : (value == 0). wrap = counting & term.
- Counting occurs only when ena=1 and the state is CNT or OVF: value ← value+1 (dir=1) or value−1 (dir=0), modulo 2^WIDTH. In RES and ERR the value is frozen; ena is ignored.
- Per-channel priority: reset > reinit > load > count.
  - reset (global) or reinit[i]: state ← RES, value ← 0, wrap_pulse ← 0.
  - load[i] (state ≠ RES): value ← load_value slice, state unchanged, no wrap, no count that cycle. load in RES is ignored.
- Transitions:
  - RES → CNT unconditionally on the next clock.
  - CNT: wrap → OVF; otherwise stay.
  - OVF: clr_overflow & !wrap → CNT. clr_overflow & wrap → OVF: the clear is consumed and the new overflow is re-armed, no error. !clr_overflow & wrap → ERR. Otherwise stay.
  - ERR: sticky; left only via reset or reinit[i]. clr_overflow has no effect.
- clr_overflow in CNT, RES, or ERR has no effect.
- Channels are fully independent. Direction may change on any cycle; term is evaluated against the dir sampled that cycle.

## Timing
- All state, value, and wrap_pulse are registered; any_err is combinational from the overflow_err flops.
- Reset values: value=0 on all channels, overflow=0, overflow_err=0, wrap_pulse=0, any_err=0, state RES.
- The first count is possible on the 2nd edge after reset deasserts: edge 1 moves RES→CNT, and ena is sampled at edge 2.
- Count latency: value updates on the same edge that samples ena.
- Wrap at edge k gives the following on the cycle after edge k, all simultaneously: the wrapped value (0 up / all-ones down), overflow=1 (or overflow_err=1), and wrap_pulse=1 for exactly one cycle.
- clr_overflow sampled at edge k clears overflow in the cycle after edge k.
- reinit mid-count or mid-OVF/ERR takes effect at the next edge, with the same timing as reset for that channel only.

## Test plan
- Reset, then ena[0]=1, dir=1, WIDTH=8 for 256 edges after leaving RES: value walks 0..255→0; overflow[0]=1 and wrap_pulse[0]=1 one cycle after the 256th count; other channels stay 0.
- Channel 1 load 0x02, dir=0, ena=1: values 1, 0, 0xFF; overflow[1] asserts with 0xFF. Continue to a second wrap without clr_overflow → overflow_err[1]=1, any_err=1, value frozen at 0xFF.
- Channel 2 in OVF with value 0xFF, ena=1, and clr_overflow=1 on the same edge: the state remains OVF, value=0, wrap_pulse=1, overflow_err stays 0.
- Channel 3 in ERR, pulse reinit[3]: value=0, overflow_err[3]=0 next cycle; counting resumes one edge later. Channels 0–2 are unaffected.
- load and ena asserted together with load_value=0xFF, dir=1: value=0xFF, no wrap or overflow. The next ena edge wraps to 0 and raises overflow.
- Global reset asserted mid-count on all channels: every output returns to its reset value at the next edge.
